// File: rtl/rs232_frame_parser.sv
// Assembles 8-byte STX/addr/cmd/data/ETX host frames from received bytes and
// emits a decoded register write/read request, or a coded rejection.
module rs232_frame_parser #(
    parameter int          TIMEOUT_CYC = 52080,
    parameter logic [15:0] CMD_WR      = 16'h3033,
    parameter logic [15:0] CMD_RD      = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_err,
    output logic [15:0] frame_addr,
    output logic [15:0] frame_data,
    output logic        cmd_wr,
    output logic        cmd_rd,
    output logic        frame_err,
    output logic [2:0]  err_code,
    output logic        busy
);
    localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

    state_t        state_reg, state_next;
    logic [2:0]    idx_reg, idx_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic [15:0]   addr_reg, addr_next;
    logic [15:0]   cmd_reg, cmd_next;
    logic [15:0]   data_reg, data_next;
    logic [7:0]    etx_reg, etx_next;
    logic [15:0]   frame_addr_next, frame_data_next;
    logic          cmd_wr_next, cmd_rd_next, frame_err_next, busy_next;
    logic [2:0]    err_code_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            tmo_reg    <= '0;
            addr_reg   <= '0;
            cmd_reg    <= '0;
            data_reg   <= '0;
            etx_reg    <= '0;
            frame_addr <= '0;
            frame_data <= '0;
            cmd_wr     <= 1'b0;
            cmd_rd     <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
            busy       <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            tmo_reg    <= tmo_next;
            addr_reg   <= addr_next;
            cmd_reg    <= cmd_next;
            data_reg   <= data_next;
            etx_reg    <= etx_next;
            frame_addr <= frame_addr_next;
            frame_data <= frame_data_next;
            cmd_wr     <= cmd_wr_next;
            cmd_rd     <= cmd_rd_next;
            frame_err  <= frame_err_next;
            err_code   <= err_code_next;
            busy       <= busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        tmo_next        = tmo_reg;
        addr_next       = addr_reg;
        cmd_next        = cmd_reg;
        data_next       = data_reg;
        etx_next        = etx_reg;
        frame_addr_next = frame_addr;
        frame_data_next = frame_data;
        cmd_wr_next     = 1'b0;
        cmd_rd_next     = 1'b0;
        frame_err_next  = 1'b0;
        err_code_next   = err_code;

        case (state_reg)
            IDLE: begin
                tmo_next = '0;
                if (rx_valid && rx_data == 8'h02) begin
                    idx_next   = 3'd1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                // Receiver error beats a simultaneous byte; a byte beats the timeout.
                if (rx_err) begin
                    frame_err_next = 1'b1;
                    err_code_next  = 3'd4;
                    idx_next       = '0;
                    tmo_next       = '0;
                    state_next     = IDLE;
                end else if (rx_valid) begin
                    tmo_next = '0;
                    idx_next = idx_reg + 3'd1;
                    case (idx_reg)
                        3'd1:    addr_next[15:8] = rx_data;
                        3'd2:    addr_next[7:0]  = rx_data;
                        3'd3:    cmd_next[15:8]  = rx_data;
                        3'd4:    cmd_next[7:0]   = rx_data;
                        3'd5:    data_next[15:8] = rx_data;
                        3'd6:    data_next[7:0]  = rx_data;
                        default: etx_next        = rx_data;
                    endcase
                    if (idx_reg == 3'd7) begin
                        idx_next   = '0;
                        state_next = CHECK;
                    end
                end else if (tmo_reg == TMO_MAX) begin
                    frame_err_next = 1'b1;
                    err_code_next  = 3'd3;
                    idx_next       = '0;
                    tmo_next       = '0;
                    state_next     = IDLE;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (etx_reg != 8'h03) begin
                    frame_err_next = 1'b1;
                    err_code_next  = 3'd1;
                end else if (cmd_reg != CMD_WR && cmd_reg != CMD_RD) begin
                    frame_err_next = 1'b1;
                    err_code_next  = 3'd2;
                end else begin
                    frame_addr_next = addr_reg;
                    frame_data_next = data_reg;
                    cmd_wr_next     = (cmd_reg == CMD_WR);
                    cmd_rd_next     = (cmd_reg != CMD_WR);
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
                tmo_next   = '0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end
endmodule

// File: doc/rs232_frame_parser.md
# rs232_frame_parser

Byte-to-frame parser that sits directly downstream of the RS232 receive path in `RS232_PACKAGE`. It consumes one received byte per strobe and assembles fixed 8-byte host frames (STX, address, command, data, ETX). It validates each frame and emits a decoded register write or read request. It also flags malformed, interrupted or stalled frames so the register side never acts on a partial packet.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 52080: maximum clk cycles allowed between bytes inside a frame. This is 4 byte times at 38400 baud with a 50 MHz clk.
- `CMD_WR`, default 16'h3033: command word that means register write.
- `CMD_RD`, default 16'h0000: command word that means register read.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a complete received byte.
- `rx_data`  in  8  received byte.
- `rx_err`  in  1  one-cycle strobe: receiver framing error (bad stop bit).
- `frame_addr`  out  16  register address, {byte1, byte2}.
- `frame_data`  out  16  data word, {byte5, byte6}.
- `cmd_wr`  out  1  one-cycle pulse: valid write frame decoded.
- `cmd_rd`  out  1  one-cycle pulse: valid read frame decoded.
- `frame_err`  out  1  one-cycle pulse: frame rejected.
- `err_code`  out  3  cause of the last rejection; held until the next rejection.
- `busy`  out  1  high while a frame is being collected.

## Operation
- Frame layout: byte0 = 8'h02 (STX); bytes1-2 = address, MSB first; bytes3-4 = command, MSB first; bytes5-6 = data, MSB first; byte7 = 8'h03 (ETX).
- States: IDLE, COLLECT, CHECK.
- IDLE:
  - Bytes other than 8'h02 are discarded silently.
  - 8'h02 sets byte index to 1, clears the timeout counter, and moves to COLLECT.
- COLLECT:
  - Each `rx_valid` stores the byte at the current index into the shift/field registers, increments the index and clears the timeout counter.
  - The byte at index 7 moves the block to CHECK with the byte latched.
  - 8'h02 and 8'h03 at indices 1-6 are ordinary data. There is no resync on STX.
- CHECK (one cycle), evaluated in this order:
  - byte7 != 8'h03: reject, `err_code` = 1.
  - command not equal to `CMD_WR` or `CMD_RD`: reject, `err_code` = 2.
  - Otherwise pulse `cmd_wr` or `cmd_rd`.
  - CHECK always returns to IDLE.
- Timeout: in COLLECT the counter increments every cycle without `rx_valid`. When it reaches `TIMEOUT_CYC`, the frame is rejected with `err_code` = 3 and the block returns to IDLE.
- `rx_err` in COLLECT: reject, `err_code` = 4, return to IDLE. `rx_err` in IDLE is ignored.
- `frame_addr` and `frame_data` update only on an accepted frame, in the same cycle as the cmd pulse, and hold until the next accepted frame. Rejected frames never change them.
- `busy` = 1 in COLLECT and CHECK.

## Timing
- Reset values: `frame_addr` = 0, `frame_data` = 0, `cmd_wr` = 0, `cmd_rd` = 0, `frame_err` = 0, `err_code` = 0, `busy` = 0, state IDLE, index 0, timeout counter 0.
- All outputs are registered.
- Latency: `rx_valid` on ETX at cycle N moves to CHECK at N+1. `cmd_wr`, `cmd_rd` or `frame_err` are high during cycle N+2 for exactly one cycle.
- The next frame's STX is accepted from cycle N+2 onward. The receiver cannot deliver bytes faster than one per ~13000 cycles, so no byte is lost.
- Simultaneous `rx_valid` and `rx_err` in COLLECT: `rx_err` wins, the byte is dropped, `err_code` = 4.
- Timeout reached in the same cycle as `rx_valid`: the byte wins and the counter clears.
- `rx_valid` during CHECK is ignored.
- The timeout counter is sized to `$clog2(TIMEOUT_CYC+1)` bits and saturates. It is never active in IDLE.
- Reset asserted mid-frame: immediate return to IDLE with all outputs at reset values. The partial frame is discarded with no `frame_err`.
- At most one of `cmd_wr`, `cmd_rd`, `frame_err` is high in any cycle.

## Test plan
- Write frame 02 30 32 30 33 01 C8 03 (bytes 13020 cycles apart) -> one `cmd_wr` pulse 2 cycles after ETX; `frame_addr` = 16'h3032, `frame_data` = 16'h01C8; `frame_err` stays 0.
- Read frame 02 30 32 00 00 00 64 03 sent right after the write -> one `cmd_rd` pulse; `frame_data` = 16'h0064; `frame_addr` = 16'h3032.
- Garbage bytes 55 AA, then frame 02 30 32 30 33 02 03 03 -> garbage ignored; `cmd_wr` fires with `frame_data` = 16'h0203, confirming embedded STX/ETX are treated as data.
- Frame with ETX replaced by 04 -> `frame_err` pulse, `err_code` = 1; command 12 34 -> `err_code` = 2. In both cases `frame_addr` and `frame_data` keep the previous values.
- Stop after byte 3, idle 52080 cycles -> `frame_err` with `err_code` = 3 and `busy` low. A following valid frame is then accepted normally.
- `rx_err` at byte 4 -> `err_code` = 4. Reset pulse at byte 5 of the next frame -> outputs go to 0 with no `frame_err`, and the next full frame is accepted.
